start_for_pe_srl_fifo: RTL and testbench
========================================

Name: start_for_pe_srl_fifo

Overview:
Start-token FIFO between a producer dataflow process and its PE_i4xi4 consumer inside Linear_Layer_i4xi4_q. It provides the producer/consumer handshake, occupancy tracking and head-of-queue addressing. Storage is an internal SRL-style shift array that shifts on every accepted write and is read at a computed address. One instance sits on each start_for channel feeding a PE process.

Parameters:
DATA_WIDTH, 1, width of each token.
ADDR_WIDTH, 4, width of the shift-array read address. DEPTH must be at most 2^ADDR_WIDTH; elaboration fails otherwise.
DEPTH, 12, maximum number of tokens held.

Ports:
clk  input  1  single clock; all state is updated on its rising edge.
reset  input  1  synchronous, active-high reset.
if_full_n  output  1  high = space available (registered).
if_write_ce  input  1  write clock-enable.
if_write  input  1  write request.
if_din  input  DATA_WIDTH  write data.
if_empty_n  output  1  high = token available (registered).
if_read_ce  input  1  read clock-enable.
if_read  input  1  read request / pop.
if_dout  output  DATA_WIDTH  head-of-queue token (oldest entry).

Behaviour:
- push = if_write & if_write_ce & if_full_n.
- pop = if_read & if_read_ce & if_empty_n.
- Requests without the matching enable, a write while full, and a read while empty are all ignored. No state changes for any of these.
- Occupancy counter cnt: width ADDR_WIDTH+1, range 0..DEPTH.
- Shift array mem[0..DEPTH-1]:
  - On push: mem[i+1] <= mem[i] for every i, then mem[0] <= if_din.
  - Array contents are not reset.
- if_dout = mem[cnt-1], combinational from cnt and the array, with no added register stage.
  - Valid only while if_empty_n=1.
  - Don't-care while empty; the bench must not check it then.
- Per-cycle transitions:
  - push only: cnt+1; if_empty_n<=1; if_full_n<=(cnt+1 != DEPTH).
  - pop only: cnt-1; if_full_n<=1; if_empty_n<=(cnt != 1).
  - push & pop together: array shifts, cnt unchanged, flags unchanged. if_dout then shows the next-oldest token, which is the prior mem[cnt-2] moved to index cnt-1. When cnt=1, the new token becomes the head.
  - neither: hold all state.
- Latency:
  - Write to visibility is 1 cycle: if_empty_n rises on the edge after the push.
  - Pop to next head is 1 cycle.
  - Throughput is 1 push and 1 pop per cycle.
- Full: if_full_n falls on the edge at which cnt reaches DEPTH. A write in that state is dropped and the array does not shift. A pop in that state raises if_full_n on the next edge.
- Empty: if_empty_n falls on the edge at which cnt reaches 0.
- Reset (synchronous; takes priority over push and pop in the same cycle):
  - cnt<=0, if_empty_n<=0, if_full_n<=1.
  - Tokens in flight are discarded. Reset mid-operation has the same effect.
- if_dout has no reset value.

Test Plan:
1. Reset: assert reset for 2 cycles with if_write=1 and if_read=1 -> if_full_n=1, if_empty_n=0 after reset; the next cycle accepts a push.
2. Fill and drain: push 0,1,0,1,... 12 times -> if_empty_n=1 from cycle 2; if_full_n=0 after the 12th push. A 13th write is dropped. Pop 12 -> outputs in order 0,1,0,1,... with DATA_WIDTH=1. Then if_empty_n=0 and if_full_n=1.
3. Simultaneous traffic: preload 3 tokens (1,0,1), then push and pop for 5 cycles with din 0,0,1,1,0 -> pops emit 1,0,1,0,0; cnt stays 3; flags never change.
4. Clock-enable gating: if_write=1 with if_write_ce=0 for 4 cycles -> if_empty_n stays 0. With 2 tokens held, if_read=1 and if_read_ce=0 -> if_dout is stable and cnt stays 2.
5. Boundary pops: cnt=1 with push+pop of din=0 -> if_empty_n stays 1 and if_dout=0. Full with push+pop -> write dropped, one pop taken, if_full_n rises next cycle.
6. Mid-operation reset: 7 tokens held, assert reset with push and pop both asserted -> next cycle if_empty_n=0 and if_full_n=1; a subsequent single push/pop returns the new token.

Source files
------------

// File: rtl/start_for_pe_srl_fifo_if.sv
// start_for_pe_srl_fifo_if: producer/consumer handshake bundle of the start-token FIFO
interface start_for_pe_srl_fifo_if #(parameter int DATA_WIDTH = 1);
    logic                  if_full_n;
    logic                  if_write_ce;
    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_empty_n;
    logic                  if_read_ce;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
    modport master (input if_full_n, if_empty_n, if_dout, output if_write_ce, if_write, if_din, if_read_ce, if_read);
    modport slave (output if_full_n, if_empty_n, if_dout, input if_write_ce, if_write, if_din, if_read_ce, if_read);
endinterface

// File: rtl/start_for_pe_srl_fifo.sv
// start_for_pe_srl_fifo: SRL-style start-token FIFO; newest token at index 0, head at cnt-1
module start_for_pe_srl_fifo #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 12
) (
    input logic                    clk,
    input logic                    reset,
    start_for_pe_srl_fifo_if.slave s
);
    if (DEPTH > 2 ** ADDR_WIDTH || DEPTH < 2) begin : g_bad_depth
        $error("start_for_pe_srl_fifo: DEPTH must be 2..2**ADDR_WIDTH");
    end
    localparam logic [ADDR_WIDTH:0] L_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
    logic [DEPTH-1:0][DATA_WIDTH-1:0] r_mem;
    logic [ADDR_WIDTH:0]              r_cnt;
    logic                             r_full_n;
    logic                             r_empty_n;
    logic                             w_push;
    logic                             w_pop;
    logic [ADDR_WIDTH-1:0]            w_addr;
    assign w_push = s.if_write & s.if_write_ce & r_full_n;
    assign w_pop  = s.if_read & s.if_read_ce & r_empty_n;
    assign w_addr = ADDR_WIDTH'(r_cnt - 1'b1);
    assign s.if_full_n  = r_full_n;
    assign s.if_empty_n = r_empty_n;
    assign s.if_dout    = r_mem[w_addr];
    // storage carries no reset; only the occupancy and flags do
    always_ff @(posedge clk) begin
        if (w_push && !reset) r_mem <= {r_mem[DEPTH-2:0], s.if_din};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_empty_n <= 1'b0;
            r_full_n  <= 1'b1;
        end else if (w_push && !w_pop) begin
            r_cnt     <= r_cnt + 1'b1;
            r_empty_n <= 1'b1;
            r_full_n  <= (r_cnt + 1'b1) != L_DEPTH;
        end else if (w_pop && !w_push) begin
            r_cnt     <= r_cnt - 1'b1;
            r_full_n  <= 1'b1;
            r_empty_n <= r_cnt != 1;
        end
    end
endmodule

// File: tb/tb_start_for_pe_srl_fifo.sv
// tb_start_for_pe_srl_fifo: directed self-checking bench for the start-token FIFO
module tb_start_for_pe_srl_fifo;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    start_for_pe_srl_fifo_if #(.DATA_WIDTH(1)) bus ();
    start_for_pe_srl_fifo #(.DATA_WIDTH(1), .ADDR_WIDTH(4), .DEPTH(12)) dut (
        .clk   (clk),
        .reset (reset),
        .s     (bus)
    );
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.if_write = 1'b0; bus.if_write_ce = 1'b1; bus.if_din = 1'b0;
        bus.if_read = 1'b0; bus.if_read_ce = 1'b1;
    endtask

    task automatic push(input logic d);
        bus.if_write = 1'b1; bus.if_din = d;
        tick();
        idle();
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.if_write = 1'b1; bus.if_read = 1'b1; bus.if_din = 1'b1;
        tick(); tick();
        reset = 1'b0; idle();
        total++; if (bus.if_full_n !== 1'b1) begin bad++; $display("FAIL reset_full_n got=%b want=1", bus.if_full_n); end
        total++; if (bus.if_empty_n !== 1'b0) begin bad++; $display("FAIL reset_empty_n got=%b want=0", bus.if_empty_n); end
        push(1'b1);
        total++; if (bus.if_empty_n !== 1'b1) begin bad++; $display("FAIL reset_push_empty_n got=%b want=1", bus.if_empty_n); end
        total++; if (bus.if_dout !== 1'b1) begin bad++; $display("FAIL reset_push_dout got=%b want=1", bus.if_dout); end
        bus.if_read = 1'b1; tick(); idle();
        total++; if (bus.if_empty_n !== 1'b0) begin bad++; $display("FAIL reset_pop_empty_n got=%b want=0", bus.if_empty_n); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 12; i++) begin
            push(1'(i));
            total++; if (bus.if_empty_n !== 1'b1) begin bad++; $display("FAIL fill_empty_n[%0d] got=%b want=1", i, bus.if_empty_n); end
            total++; if (bus.if_full_n !== (i != 11)) begin bad++; $display("FAIL fill_full_n[%0d] got=%b want=%b", i, bus.if_full_n, i != 11); end
        end
        push(1'b1);
        total++; if (bus.if_full_n !== 1'b0) begin bad++; $display("FAIL fill_drop_full_n got=%b want=0", bus.if_full_n); end
        for (int i = 0; i < 12; i++) begin
            total++; if (bus.if_dout !== 1'(i)) begin bad++; $display("FAIL drain_dout[%0d] got=%b want=%b", i, bus.if_dout, 1'(i)); end
            bus.if_read = 1'b1; tick(); idle();
        end
        total++; if (bus.if_empty_n !== 1'b0) begin bad++; $display("FAIL drain_empty_n got=%b want=0", bus.if_empty_n); end
        total++; if (bus.if_full_n !== 1'b1) begin bad++; $display("FAIL drain_full_n got=%b want=1", bus.if_full_n); end
    endtask

    task automatic test_simultaneous();
        logic [4:0] dins;
        logic [4:0] outs;
        logic [2:0] tail;
        dins = 5'b01100;
        outs = 5'b00101;
        tail = 3'b011;
        push(1'b1); push(1'b0); push(1'b1);
        for (int k = 0; k < 5; k++) begin
            total++; if (bus.if_dout !== outs[k]) begin bad++; $display("FAIL simul_dout[%0d] got=%b want=%b", k, bus.if_dout, outs[k]); end
            bus.if_write = 1'b1; bus.if_read = 1'b1; bus.if_din = dins[k];
            tick(); idle();
            total++; if ({bus.if_empty_n, bus.if_full_n} !== 2'b11) begin bad++; $display("FAIL simul_flags[%0d] got=%b want=11", k, {bus.if_empty_n, bus.if_full_n}); end
        end
        for (int k = 0; k < 3; k++) begin
            total++; if (bus.if_dout !== tail[k]) begin bad++; $display("FAIL simul_tail[%0d] got=%b want=%b", k, bus.if_dout, tail[k]); end
            bus.if_read = 1'b1; tick(); idle();
        end
        total++; if (bus.if_empty_n !== 1'b0) begin bad++; $display("FAIL simul_cnt_empty_n got=%b want=0", bus.if_empty_n); end
    endtask

    task automatic test_clock_enable();
        bus.if_write = 1'b1; bus.if_write_ce = 1'b0; bus.if_din = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (bus.if_empty_n !== 1'b0) begin bad++; $display("FAIL ce_write_empty_n[%0d] got=%b want=0", k, bus.if_empty_n); end
        end
        idle();
        push(1'b1); push(1'b0);
        bus.if_read = 1'b1; bus.if_read_ce = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (bus.if_dout !== 1'b1) begin bad++; $display("FAIL ce_read_dout[%0d] got=%b want=1", k, bus.if_dout); end
        end
        idle();
        bus.if_read = 1'b1; tick();
        total++; if (bus.if_dout !== 1'b0) begin bad++; $display("FAIL ce_second_dout got=%b want=0", bus.if_dout); end
        tick(); idle();
        total++; if (bus.if_empty_n !== 1'b0) begin bad++; $display("FAIL ce_cnt_empty_n got=%b want=0", bus.if_empty_n); end
    endtask

    task automatic test_boundary();
        push(1'b1);
        total++; if (bus.if_dout !== 1'b1) begin bad++; $display("FAIL one_pre_dout got=%b want=1", bus.if_dout); end
        bus.if_write = 1'b1; bus.if_read = 1'b1; bus.if_din = 1'b0;
        tick(); idle();
        total++; if (bus.if_empty_n !== 1'b1) begin bad++; $display("FAIL one_empty_n got=%b want=1", bus.if_empty_n); end
        total++; if (bus.if_dout !== 1'b0) begin bad++; $display("FAIL one_dout got=%b want=0", bus.if_dout); end
        bus.if_read = 1'b1; tick(); idle();
        for (int i = 0; i < 12; i++) push(~1'(i));
        total++; if (bus.if_full_n !== 1'b0) begin bad++; $display("FAIL full_pre_full_n got=%b want=0", bus.if_full_n); end
        total++; if (bus.if_dout !== 1'b1) begin bad++; $display("FAIL full_pre_dout got=%b want=1", bus.if_dout); end
        bus.if_write = 1'b1; bus.if_read = 1'b1; bus.if_din = 1'b0;
        tick(); idle();
        total++; if (bus.if_full_n !== 1'b1) begin bad++; $display("FAIL full_pop_full_n got=%b want=1", bus.if_full_n); end
        for (int i = 1; i < 12; i++) begin
            total++; if (bus.if_dout !== ~1'(i)) begin bad++; $display("FAIL full_drain_dout[%0d] got=%b want=%b", i, bus.if_dout, ~1'(i)); end
            bus.if_read = 1'b1; tick(); idle();
        end
        total++; if (bus.if_empty_n !== 1'b0) begin bad++; $display("FAIL full_drain_empty_n got=%b want=0", bus.if_empty_n); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 7; i++) push(1'b1);
        reset = 1'b1; bus.if_write = 1'b1; bus.if_read = 1'b1; bus.if_din = 1'b1;
        tick();
        reset = 1'b0; idle();
        total++; if (bus.if_empty_n !== 1'b0) begin bad++; $display("FAIL midrst_empty_n got=%b want=0", bus.if_empty_n); end
        total++; if (bus.if_full_n !== 1'b1) begin bad++; $display("FAIL midrst_full_n got=%b want=1", bus.if_full_n); end
        push(1'b0);
        total++; if (bus.if_dout !== 1'b0) begin bad++; $display("FAIL midrst_dout got=%b want=0", bus.if_dout); end
        bus.if_read = 1'b1; tick(); idle();
        total++; if (bus.if_empty_n !== 1'b0) begin bad++; $display("FAIL midrst_pop_empty_n got=%b want=0", bus.if_empty_n); end
    endtask

    initial begin
        idle();
        test_reset();
        test_fill_drain();
        test_simultaneous();
        test_clock_enable();
        test_boundary();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
